// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing, scan-bus addressing and latency-aligned colour/sync output
module vga_scan_ctrl #(
  parameter int PX_LATENCY = 1,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] px_color,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        active,
  output logic        fresh,
  output logic [7:0]  frame_cnt,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);
  localparam int D = PX_LATENCY + 1;
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SBEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SEND = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SBEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SEND = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]   h_cnt, v_cnt;
  logic         h_vis, v_vis, hs_raw, vs_raw, act_pre, h_wrap;
  logic [D-1:0] hs_sr, vs_sr;

  assign h_vis    = h_cnt < H_VIS;
  assign v_vis    = v_cnt < V_VIS;
  assign h_wrap   = h_cnt == H_LAST;
  assign col_addr = h_vis ? h_cnt : 10'h3FF;
  assign row_addr = v_vis ? v_cnt[8:0] : 9'h1FF;
  assign active   = h_vis && v_vis;
  assign hs_raw   = !(h_cnt >= H_SBEG && h_cnt <= H_SEND);
  assign vs_raw   = !(v_cnt >= V_SBEG && v_cnt <= V_SEND);
  assign hs       = hs_sr[D-1];
  assign vs       = vs_sr[D-1];

  // active must be delayed by PX_LATENCY to gate the colour arriving on the same clock
  generate
    if (PX_LATENCY == 0) begin : g_nodly
      assign act_pre = active;
    end else begin : g_dly
      logic [PX_LATENCY-1:0] act_sr;
      always_ff @(posedge clk)
        act_sr <= !rst_n ? '0 : (act_sr << 1) | PX_LATENCY'(active);
      assign act_pre = act_sr[PX_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      hs_sr     <= '1;
      vs_sr     <= '1;
      fresh     <= 1'b0;
      frame_cnt <= '0;
      {r, g, b} <= 12'h000;
    end else begin
      h_cnt     <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      frame_cnt <= frame_cnt + 8'(h_wrap && v_cnt == V_LAST);
      hs_sr     <= (hs_sr << 1) | D'(hs_raw);
      vs_sr     <= (vs_sr << 1) | D'(vs_raw);
      fresh     <= v_vis;
      {r, g, b} <= act_pre ? px_color : 12'h000;
    end
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: full-size and shrunken-timing instances checked against a raster-position model
module tb_vga_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] px [2];
  logic [8:0]  row [2];
  logic [9:0]  col [2];
  logic        act [2], fresh [2], hs [2], vs [2];
  logic [7:0]  fc [2];
  logic [3:0]  rr [2], gg [2], bb [2];

  int ha [2] = '{640, 8};
  int hf [2] = '{16, 1};
  int hw [2] = '{96, 2};
  int hb [2] = '{48, 1};
  int va [2] = '{480, 6};
  int vf [2] = '{10, 1};
  int vw [2] = '{2, 1};
  int vb [2] = '{33, 1};
  int lat [2] = '{1, 0};

  int checks = 0, passes = 0;

  vga_scan_ctrl #(.PX_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .px_color(px[0]), .row_addr(row[0]), .col_addr(col[0]),
    .active(act[0]), .fresh(fresh[0]), .frame_cnt(fc[0]), .hs(hs[0]), .vs(vs[0]),
    .r(rr[0]), .g(gg[0]), .b(bb[0]));

  vga_scan_ctrl #(.PX_LATENCY(0), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .px_color(px[1]), .row_addr(row[1]), .col_addr(col[1]),
    .active(act[1]), .fresh(fresh[1]), .frame_cnt(fc[1]), .hs(hs[1]), .vs(vs[1]),
    .r(rr[1]), .g(gg[1]), .b(bb[1]));

  always #5 clk = ~clk;

  // instance 0 sees a ground-like layer with one clock of latency, instance 1 sees noise
  always @(posedge clk) begin
    px[0] <= {col[0][3:0], row[0][3:0], 4'hA};
    px[1] <= 12'($urandom);
  end

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a == e) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, a, a, e, e);
  endtask

  function automatic int htot(input int i);
    return ha[i] + hf[i] + hw[i] + hb[i];
  endfunction
  function automatic int vtot(input int i);
    return va[i] + vf[i] + vw[i] + vb[i];
  endfunction

  int n [2];
  int nrec [2][8];
  int e_hs [2], e_vs [2], e_rgb [2], e_fresh [2], e_fc [2];
  int cyc = 0, last_rst = 0;
  bit known = 0;

  always @(negedge clk) begin : model
    int h, v, k, kh, kv, src;
    for (int i = 0; i < 2; i++) begin
      h = n[i] % htot(i);
      v = (n[i] / htot(i)) % vtot(i);
      if (known) begin
        chk($sformatf("col%0d", i), int'(col[i]), h < ha[i] ? h : 1023);
        chk($sformatf("row%0d", i), int'(row[i]), v < va[i] ? v : 511);
        chk($sformatf("active%0d", i), int'(act[i]), int'(h < ha[i] && v < va[i]));
        chk($sformatf("hs%0d", i), int'(hs[i]), e_hs[i]);
        chk($sformatf("vs%0d", i), int'(vs[i]), e_vs[i]);
        chk($sformatf("rgb%0d", i), int'({rr[i], gg[i], bb[i]}), e_rgb[i]);
        chk($sformatf("fresh%0d", i), int'(fresh[i]), e_fresh[i]);
        chk($sformatf("frame%0d", i), int'(fc[i]), e_fc[i]);
      end
      nrec[i][cyc % 8] = n[i];
      if (!rst_n) begin
        n[i] = 0; e_hs[i] = 1; e_vs[i] = 1; e_rgb[i] = 0; e_fresh[i] = 0; e_fc[i] = 0;
      end else begin
        src = cyc - lat[i];
        if (src <= last_rst) begin
          e_hs[i] = 1; e_vs[i] = 1; e_rgb[i] = 0;
        end else begin
          k  = nrec[i][src % 8];
          kh = k % htot(i);
          kv = (k / htot(i)) % vtot(i);
          e_hs[i]  = int'(!(kh >= ha[i] + hf[i] && kh < ha[i] + hf[i] + hw[i]));
          e_vs[i]  = int'(!(kv >= va[i] + vf[i] && kv < va[i] + vf[i] + vw[i]));
          e_rgb[i] = (kh < ha[i] && kv < va[i]) ? int'(px[i]) : 0;
        end
        e_fresh[i] = int'(v < va[i]);
        n[i]++;
        e_fc[i] = (n[i] / (htot(i) * vtot(i))) % 256;
      end
    end
    if (!rst_n) begin
      last_rst = cyc;
      known = 1;
    end
    cyc++;
  end

  initial begin
    int cnt, lw, vslow, falls;
    logic prev;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hs", int'(hs[0]), 1);
    chk("rst_vs", int'(vs[0]), 1);
    chk("rst_rgb", int'({rr[0], gg[0], bb[0]}), 0);
    chk("rst_fresh", int'(fresh[0]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("fresh_first_edge", int'(fresh[0]), 1);
    cnt = 1;
    while (hs[0] && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    chk("hs_first_fall", cnt, 658);
    lw = 0;
    while (!hs[0] && lw < 200) begin @(posedge clk); #1; lw++; end
    chk("hs_low_len", lw, 96);
    while (hs[0] && lw < 2000) begin @(posedge clk); #1; lw++; end
    chk("hs_period", lw, 800);
    cnt = 0;
    while (!(col[0] == 10'd5 && row[0] == 9'd16) && cnt < 20000) begin @(posedge clk); #1; cnt++; end
    chk("ground_addr_found", int'(col[0] == 10'd5 && row[0] == 9'd16), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("ground_px", int'({rr[0], gg[0], bb[0]}), 12'h50A);
    repeat (693) @(posedge clk);
    #1;
    chk("hs_in_pulse", int'(hs[0]), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_col", int'(col[0]), 0);
    chk("rst_mid_row", int'(row[0]), 0);
    chk("rst_mid_active", int'(act[0]), 1);
    chk("rst_mid_frame", int'(fc[0]), 0);
    chk("rst_mid_hs", int'(hs[0]), 1);
    chk("rst_mid_frame_small", int'(fc[1]), 0);
    vslow = 0; falls = 0; prev = fresh[1];
    for (int j = 0; j < 216; j++) begin
      @(posedge clk); #1;
      if (!vs[1]) vslow++;
      if (prev && !fresh[1]) falls++;
      prev = fresh[1];
    end
    chk("vs_low_2frames", vslow, 24);
    chk("fresh_falls_2frames", falls, 2);
    chk("frame_after_2", int'(fc[1]), 2);
    cnt = 0;
    while (fc[1] != 8'd255 && cnt < 30000) begin @(posedge clk); #1; cnt++; end
    chk("frame_reach_255", int'(fc[1]), 255);
    cnt = 0;
    while (fc[1] == 8'd255 && cnt < 200) begin @(posedge clk); #1; cnt++; end
    chk("frame_255_len", cnt, 108);
    chk("frame_wrap", int'(fc[1]), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
